// File: rtl/tpu_ctrl_pkg.sv
// Shared types for the TPU input-datapath controller: scheduler states,
// layer configuration record and patch geometry.
package tpu_ctrl_pkg;

    localparam int PATCH_SIZE = 4;
    localparam int CFG_BITS   = 16;

    typedef enum logic [3:0] {
        IDLE,
        ISSUE,
        WAIT_PATCH,
        WAIT_SA,
        RUN_SW,
        WAIT_SW,
        NEXT,
        DONE,
        ERROR
    } sched_state_e;

    typedef struct packed {
        logic [CFG_BITS-1:0] width;
        logic [CFG_BITS-1:0] height;
        logic [CFG_BITS-1:0] channels;
    } cfg_t;

    // Number of window positions along one axis with stride 1.
    function automatic logic [CFG_BITS-1:0] window_span(input logic [CFG_BITS-1:0] dim);
        return dim - CFG_BITS'(PATCH_SIZE - 1);
    endfunction

endpackage

// File: rtl/sched_watchdog.sv
// Down-counting watchdog: reloaded on every state entry, counts while enabled,
// flags expiry on the last allowed cycle so the caller can leave on the next edge.
module sched_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(TIMEOUT_CYCLES - 1);
        end else if (enable && count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expire = enable && (count == '0);

endmodule

// File: rtl/conv_patch_scheduler.sv
// Per-layer sequencer for patch extractor -> sliding window -> systolic array:
// issues start/advance pulses, waits on datapath handshakes, counts patches, flags errors.
module conv_patch_scheduler
    import tpu_ctrl_pkg::*;
#(
    parameter int IMG_W          = 32,
    parameter int IMG_H          = 32,
    parameter int MAX_CHANNELS   = 64,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int WW  = $clog2(IMG_W + 1),
    localparam int HW  = $clog2(IMG_H + 1),
    localparam int CW  = $clog2(MAX_CHANNELS + 1),
    localparam int PCW = $clog2(IMG_W * IMG_H * MAX_CHANNELS + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start_layer,
    input  logic           abort,
    input  logic [WW-1:0]  cfg_width,
    input  logic [HW-1:0]  cfg_height,
    input  logic [CW-1:0]  cfg_channels,
    input  logic           sa_ready,
    input  logic           patch_done,
    input  logic           sw_done,
    input  logic           extract_complete,
    output logic [WW-1:0]  dp_width,
    output logic [HW-1:0]  dp_height,
    output logic [CW-1:0]  dp_channels,
    output logic           start_patch,
    output logic           start_sw,
    output logic           advance_patch,
    output logic           busy,
    output logic           layer_done,
    output logic [PCW-1:0] patch_count,
    output logic           err_timeout,
    output logic           err_count,
    output logic           err_cfg
);

    sched_state_e   state, state_nxt;
    cfg_t           cfg_q, cfg_in;
    logic [PCW-1:0] expected;
    logic           entered;
    logic           cfg_ok, last_patch;
    logic           accept, reject, count_inc, count_err, to_error;
    logic           wd_load, wd_enable, expire;

    assign cfg_in = '{width:    CFG_BITS'(cfg_width),
                      height:   CFG_BITS'(cfg_height),
                      channels: CFG_BITS'(cfg_channels)};

    assign cfg_ok = (cfg_width    >= WW'(PATCH_SIZE)) && (cfg_width  <= WW'(IMG_W)) &&
                    (cfg_height   >= HW'(PATCH_SIZE)) && (cfg_height <= HW'(IMG_H)) &&
                    (cfg_channels != '0)              && (cfg_channels <= CW'(MAX_CHANNELS));

    // Compared one bit wider so a saturated count cannot alias onto expected.
    assign last_patch = (({1'b0, patch_count} + (PCW+1)'(1)) == {1'b0, expected});

    assign wd_load   = (state_nxt != state);
    assign wd_enable = (state == WAIT_PATCH) || (state == WAIT_SW);

    sched_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .load   (wd_load),
        .enable (wd_enable),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            entered <= 1'b0;
        end else begin
            state   <= state_nxt;
            entered <= (state_nxt != state);
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        count_inc = 1'b0;
        count_err = 1'b0;
        to_error  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start_layer) begin
                        if (cfg_ok) begin
                            accept    = 1'b1;
                            state_nxt = ISSUE;
                        end else begin
                            reject = 1'b1;
                        end
                    end
                end
                ISSUE: state_nxt = WAIT_PATCH;
                WAIT_PATCH: begin
                    // patch_done is a level; on the entry cycle it still reflects the previous patch.
                    if (!entered && patch_done) begin
                        state_nxt = WAIT_SA;
                    end else if (expire) begin
                        state_nxt = ERROR;
                        to_error  = 1'b1;
                    end
                end
                WAIT_SA: begin
                    if (sa_ready) state_nxt = RUN_SW;
                end
                RUN_SW: state_nxt = WAIT_SW;
                WAIT_SW: begin
                    if (sw_done) begin
                        count_inc = 1'b1;
                        if (extract_complete || last_patch) begin
                            state_nxt = DONE;
                            count_err = (extract_complete != last_patch);
                        end else begin
                            state_nxt = NEXT;
                        end
                    end else if (expire) begin
                        state_nxt = ERROR;
                        to_error  = 1'b1;
                    end
                end
                NEXT: state_nxt = WAIT_PATCH;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_q         <= '0;
            expected      <= '0;
            start_patch   <= 1'b0;
            start_sw      <= 1'b0;
            advance_patch <= 1'b0;
            busy          <= 1'b0;
            layer_done    <= 1'b0;
            patch_count   <= '0;
            err_timeout   <= 1'b0;
            err_count     <= 1'b0;
            err_cfg       <= 1'b0;
        end else begin
            start_patch   <= (state_nxt == ISSUE);
            start_sw      <= (state_nxt == RUN_SW);
            advance_patch <= (state_nxt == NEXT);
            busy          <= !(state_nxt inside {IDLE, DONE, ERROR});
            layer_done    <= (state_nxt == DONE) && (state != DONE);
            err_cfg       <= reject;
            // Settles during ISSUE; first consumed in WAIT_SW.
            expected      <= PCW'(window_span(cfg_q.width)) *
                             PCW'(window_span(cfg_q.height)) *
                             PCW'(cfg_q.channels);
            if (abort) begin
                cfg_q       <= '0;
                patch_count <= '0;
                err_timeout <= 1'b0;
                err_count   <= 1'b0;
            end else if (accept) begin
                cfg_q       <= cfg_in;
                patch_count <= '0;
                err_timeout <= 1'b0;
                err_count   <= 1'b0;
            end else begin
                if (count_inc && patch_count != '1) patch_count <= patch_count + PCW'(1);
                if (count_err) err_count <= 1'b1;
                if (to_error) err_timeout <= 1'b1;
            end
        end
    end

    assign dp_width    = cfg_q.width[WW-1:0];
    assign dp_height   = cfg_q.height[HW-1:0];
    assign dp_channels = cfg_q.channels[CW-1:0];

endmodule

// File: tb/tb_conv_patch_scheduler.sv
// Directed bench for conv_patch_scheduler with a small datapath responder model.
module tb_conv_patch_scheduler;

    localparam int T = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_layer = 1'b0;
    logic        abort = 1'b0;
    logic [5:0]  cfg_width = '0;
    logic [5:0]  cfg_height = '0;
    logic [6:0]  cfg_channels = '0;
    logic        sa_ready = 1'b0;
    logic        patch_done, sw_done, extract_complete;
    logic [5:0]  dp_width, dp_height;
    logic [6:0]  dp_channels;
    logic        start_patch, start_sw, advance_patch, busy, layer_done;
    logic [16:0] patch_count;
    logic        err_timeout, err_count, err_cfg;

    int checks = 0;
    int passed = 0;
    int n_sp = 0, n_sw = 0, n_adv = 0, n_done = 0;
    int pd_timer = 0, sw_timer = 0, sw_n = 0;
    int model_total = 1;
    logic sw_hang = 1'b0;

    conv_patch_scheduler #(
        .IMG_W(32), .IMG_H(32), .MAX_CHANNELS(64), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .reset(reset), .start_layer(start_layer), .abort(abort),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_channels(cfg_channels),
        .sa_ready(sa_ready), .patch_done(patch_done), .sw_done(sw_done),
        .extract_complete(extract_complete),
        .dp_width(dp_width), .dp_height(dp_height), .dp_channels(dp_channels),
        .start_patch(start_patch), .start_sw(start_sw), .advance_patch(advance_patch),
        .busy(busy), .layer_done(layer_done), .patch_count(patch_count),
        .err_timeout(err_timeout), .err_count(err_count), .err_cfg(err_cfg)
    );

    always #5 clk = ~clk;

    // Datapath model: patch_done rises 3 cycles after start/advance, sw_done pulses
    // 3 cycles after start_sw, extract_complete rises with the model_total-th sw_done.
    always @(negedge clk) begin
        if (!reset) begin
            patch_done = 1'b0; sw_done = 1'b0; extract_complete = 1'b0;
            pd_timer = 0; sw_timer = 0; sw_n = 0;
        end else begin
            sw_done = 1'b0;
            if (start_patch || advance_patch) begin
                patch_done = 1'b0;
                pd_timer = 3;
                if (start_patch) begin
                    sw_n = 0;
                    extract_complete = 1'b0;
                end
            end else if (pd_timer > 0) begin
                pd_timer--;
                if (pd_timer == 0) patch_done = 1'b1;
            end
            if (start_sw && !sw_hang) begin
                sw_timer = 3;
            end else if (sw_timer > 0) begin
                sw_timer--;
                if (sw_timer == 0) begin
                    sw_done = 1'b1;
                    sw_n++;
                    extract_complete = (sw_n == model_total);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (start_patch)   n_sp++;
        if (start_sw)      n_sw++;
        if (advance_patch) n_adv++;
        if (layer_done)    n_done++;
    end

    task automatic kick(input int w, input int h, input int c);
        @(negedge clk);
        cfg_width = 6'(w); cfg_height = 6'(h); cfg_channels = 7'(c);
        start_layer = 1'b1;
        @(negedge clk);
        start_layer = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start_sw(output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (start_sw) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, start_patch, start_sw, advance_patch, layer_done, err_timeout, err_count, err_cfg} !== 8'h00)
            $display("FAIL reset_flags: got %b want 00000000",
                     {busy, start_patch, start_sw, advance_patch, layer_done, err_timeout, err_count, err_cfg});
        else passed++;
        checks++;
        if ({dp_width, dp_height, dp_channels, patch_count} !== 36'h0)
            $display("FAIL reset_data: got w=%0d h=%0d c=%0d cnt=%0d want 0", dp_width, dp_height, dp_channels, patch_count);
        else passed++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        int sp0, sw0, adv0, dn0;
        bit ok;
        sp0 = n_sp; sw0 = n_sw; adv0 = n_adv; dn0 = n_done;
        sa_ready = 1'b1; model_total = 1;
        kick(4, 4, 1);
        checks++;
        if (start_patch !== 1'b1 || busy !== 1'b1) $display("FAIL single_issue: sp=%b busy=%b want 1 1", start_patch, busy);
        else passed++;
        wait_idle(ok);
        checks++;
        if (!ok) $display("FAIL single_timeout: busy=%b want 0", busy); else passed++;
        checks++;
        if (n_sp - sp0 != 1 || n_sw - sw0 != 1 || n_adv - adv0 != 0 || n_done - dn0 != 1)
            $display("FAIL single_pulses: sp=%0d sw=%0d adv=%0d done=%0d want 1 1 0 1",
                     n_sp - sp0, n_sw - sw0, n_adv - adv0, n_done - dn0);
        else passed++;
        checks++;
        if (patch_count !== 17'd1 || dp_width !== 6'd4 || err_count !== 1'b0)
            $display("FAIL single_count: cnt=%0d w=%0d errc=%b want 1 4 0", patch_count, dp_width, err_count);
        else passed++;
    endtask

    task automatic test_multi;
        int sw0, adv0, dn0;
        bit ok;
        sw0 = n_sw; adv0 = n_adv; dn0 = n_done;
        model_total = 8;
        kick(5, 5, 2);
        repeat (4) @(negedge clk);
        // Bad config while busy must be ignored silently.
        cfg_width = 6'd3; cfg_channels = 7'd0; start_layer = 1'b1;
        @(negedge clk);
        start_layer = 1'b0;
        checks++;
        if (err_cfg !== 1'b0 || busy !== 1'b1) $display("FAIL multi_busy_start: errcfg=%b busy=%b want 0 1", err_cfg, busy);
        else passed++;
        wait_idle(ok);
        checks++;
        if (!ok) $display("FAIL multi_timeout: busy=%b want 0", busy); else passed++;
        checks++;
        if (n_adv - adv0 != 7 || n_sw - sw0 != 8 || n_done - dn0 != 1)
            $display("FAIL multi_pulses: adv=%0d sw=%0d done=%0d want 7 8 1", n_adv - adv0, n_sw - sw0, n_done - dn0);
        else passed++;
        checks++;
        if (patch_count !== 17'd8 || err_count !== 1'b0 || dp_channels !== 7'd2)
            $display("FAIL multi_count: cnt=%0d errc=%b ch=%0d want 8 0 2", patch_count, err_count, dp_channels);
        else passed++;
    endtask

    task automatic test_backpressure;
        int sw0, dn0;
        bit ok;
        sw0 = n_sw; dn0 = n_done;
        sa_ready = 1'b0; model_total = 4;
        kick(5, 5, 1);
        repeat (10000) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || err_timeout !== 1'b0 || n_sw - sw0 != 0)
            $display("FAIL bp_hold: busy=%b errto=%b sw=%0d want 1 0 0", busy, err_timeout, n_sw - sw0);
        else passed++;
        sa_ready = 1'b1;
        wait_idle(ok);
        checks++;
        if (!ok || patch_count !== 17'd4 || err_timeout !== 1'b0 || n_done - dn0 != 1)
            $display("FAIL bp_release: ok=%b cnt=%0d errto=%b done=%0d want 1 4 0 1",
                     ok, patch_count, err_timeout, n_done - dn0);
        else passed++;
    endtask

    task automatic test_timeout;
        bit found, ok;
        sw_hang = 1'b1; model_total = 1;
        kick(4, 4, 1);
        wait_start_sw(found);
        checks++;
        if (!found) $display("FAIL to_start_sw: start_sw=%b want 1", start_sw); else passed++;
        repeat (T) @(negedge clk);
        checks++;
        if ({err_timeout, busy} !== 2'b01) $display("FAIL to_early: errto,busy=%b want 01", {err_timeout, busy});
        else passed++;
        @(negedge clk);
        checks++;
        if ({err_timeout, busy} !== 2'b10) $display("FAIL to_fire: errto,busy=%b want 10", {err_timeout, busy});
        else passed++;
        sw_hang = 1'b0;
        kick(4, 4, 1);
        checks++;
        if (err_timeout !== 1'b0) $display("FAIL to_clear: errto=%b want 0", err_timeout); else passed++;
        wait_idle(ok);
        checks++;
        if (!ok || patch_count !== 17'd1) $display("FAIL to_rerun: ok=%b cnt=%0d want 1 1", ok, patch_count);
        else passed++;
    endtask

    task automatic test_cfg_and_early;
        int sp0, dn0, adv0;
        bit ok;
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        repeat (2) @(negedge clk);
        sp0 = n_sp;
        kick(3, 8, 1);
        checks++;
        if (err_cfg !== 1'b1 || busy !== 1'b0 || start_patch !== 1'b0)
            $display("FAIL cfg_reject: errcfg=%b busy=%b sp=%b want 1 0 0", err_cfg, busy, start_patch);
        else passed++;
        @(negedge clk);
        checks++;
        if (err_cfg !== 1'b0) $display("FAIL cfg_pulse_width: errcfg=%b want 0", err_cfg); else passed++;
        repeat (3) @(negedge clk);
        checks++;
        if (n_sp - sp0 != 0 || busy !== 1'b0) $display("FAIL cfg_no_start: sp=%0d busy=%b want 0 0", n_sp - sp0, busy);
        else passed++;
        dn0 = n_done; adv0 = n_adv;
        model_total = 2;
        kick(5, 5, 1);
        wait_idle(ok);
        checks++;
        if (!ok || patch_count !== 17'd2 || err_count !== 1'b1 || n_done - dn0 != 1 || n_adv - adv0 != 1)
            $display("FAIL early_complete: ok=%b cnt=%0d errc=%b done=%0d adv=%0d want 1 2 1 1 1",
                     ok, patch_count, err_count, n_done - dn0, n_adv - adv0);
        else passed++;
    endtask

    task automatic test_abort_reset;
        int sp0, dn0;
        bit found, ok;
        sw_hang = 1'b1; model_total = 1;
        kick(4, 4, 1);
        wait_start_sw(found);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (!found || {busy, start_patch, start_sw, advance_patch, layer_done, err_timeout, err_count, err_cfg} !== 8'h00
            || {dp_width, dp_height, dp_channels, patch_count} !== 36'h0)
            $display("FAIL abort_wait_sw: found=%b flags=%b w=%0d cnt=%0d want 1 00000000 0 0", found,
                     {busy, start_patch, start_sw, advance_patch, layer_done, err_timeout, err_count, err_cfg},
                     dp_width, patch_count);
        else passed++;
        sp0 = n_sp;
        @(negedge clk);
        abort = 1'b1; start_layer = 1'b1;
        cfg_width = 6'd4; cfg_height = 6'd4; cfg_channels = 7'd1;
        @(negedge clk);
        abort = 1'b0; start_layer = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || n_sp - sp0 != 0) $display("FAIL abort_priority: busy=%b sp=%0d want 0 0", busy, n_sp - sp0);
        else passed++;
        sw_hang = 1'b0; model_total = 8;
        kick(5, 5, 2);
        repeat (20) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || dp_width !== 6'd0 || patch_count !== 17'd0 || start_sw !== 1'b0)
            $display("FAIL async_reset: busy=%b w=%0d cnt=%0d sw=%b want 0 0 0 0", busy, dp_width, patch_count, start_sw);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        dn0 = n_done; model_total = 1;
        kick(4, 4, 1);
        wait_idle(ok);
        checks++;
        if (!ok || patch_count !== 17'd1 || n_done - dn0 != 1 || err_count !== 1'b0 || err_timeout !== 1'b0)
            $display("FAIL post_reset_run: ok=%b cnt=%0d done=%0d errc=%b errto=%b want 1 1 1 0 0",
                     ok, patch_count, n_done - dn0, err_count, err_timeout);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_timeout();
        test_cfg_and_early();
        test_abort_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
